i2s_rx_bram_capture: RTL and testbench
======================================

Name: i2s_rx_bram_capture

Overview:
Record-path counterpart of the playback DMA. It deserializes I2S record data from the codec (one selected channel) and writes CLIP_LEN samples into BRAM, one sample per 32-bit word at consecutive addresses. The PS arms it through a GPIO start bit and reads the clip back from BRAM after done/irq. It sits beside the playback DMA. BCLK/LRC are driven externally (codec or playback generator) and are inputs here.

Parameters:
SAMPLE_BITS, 16, bits captured per sample, MSB-first; bits beyond SAMPLE_BITS in a slot are ignored
CLIP_LEN, 64, samples written per capture
ADDR_INCREMENT, 4, BRAM byte-address step per sample
CHANNEL, 0, captured slot: 0 = left (LRC low), 1 = right (LRC high)

Ports:
clk  in  1  system clock; must be at least 8x BCLK
rst  in  1  asynchronous, active-high reset
start  in  1  level from GPIO; rising edge arms a capture
busy  out  1  high from the ARM state through the WRITE state
done  out  1  high in DONE; also drives the interrupt
sample_count  out  16  samples written in the current or last capture
i2s_bclk  in  1  bit clock (async to clk)
i2s_lrc  in  1  record LR clock (async)
i2s_recdat  in  1  record serial data (async)
BRAM_addr  out  32  byte address
BRAM_clk  out  1  equals clk
BRAM_din  out  32  write data
BRAM_en  out  1  BRAM enable
BRAM_rst  out  1  BRAM reset
BRAM_we  out  4  byte write enables

Behaviour:
- Reset values: BRAM_addr=0, BRAM_din=0, BRAM_en=0, BRAM_we=0, BRAM_rst=1, busy=0, done=0, sample_count=0, state=IDLE. BRAM_rst drops on the first clk after reset release.
- Synchronization: bclk, lrc and recdat each pass through a 2-flop synchronizer. A bclk rising edge (bre) is detected from synchronized stage 2 versus stage 3.
- Sampling: lrc and recdat are sampled only on bre.
- Slot start: a sampled lrc differing from the previous sampled lrc marks a slot boundary. The recdat bit on the NEXT bre is the MSB (standard I2S 1-bit delay).
- Bit counter: shifts SAMPLE_BITS bits MSB-first into the shift register, then saturates until the next boundary. A sample completes when the counter reaches SAMPLE_BITS in the slot whose lrc equals CHANNEL.
- start edge detection: registered; only the 0->1 transition counts.
- FSM:
  - IDLE: en=0, we=0. On start edge: clear done, sample_count=0, go to ARM.
  - ARM: wait for a slot boundary into CHANNEL, then go to CAPTURE. Any sample already in progress is discarded, so the first written sample is always complete.
  - CAPTURE: en=0, we=0. On sample complete, go to WRITE.
  - WRITE: one clk with en=1, we=4'hF, BRAM_addr=sample_count*ADDR_INCREMENT, BRAM_din = sample sign-extended to 32 bits. Next clk: sample_count+1. If the new count equals CLIP_LEN, go to DONE; otherwise go to CAPTURE.
  - DONE: en=0, we=0, done=1, busy=0. On start edge: go to ARM and clear done.
- Latency: the BRAM write is asserted 1 clk after the bre that delivers the LSB. The bre itself occurs 3 clk after the pin edge.
- start edge while busy is ignored. Holding start high does not retrigger.
- Reset mid-capture: the in-progress write is dropped and all outputs return to reset values. A new capture after reset starts at address 0.
- The opposite channel's slots are shifted but never written.
- Word index wraps never: capture stops at CLIP_LEN.

Test Plan:
- Reset -> all outputs at reset values, BRAM_rst=1; one clk after release BRAM_rst=0, no BRAM_we activity without start.
- Start edge, left channel ramp 16'h0001..16'h0040 -> 64 writes: addr 0,4,...,252; din 32'h00000001..32'h00000040; we=4'hF for exactly one clk each; done=1 and sample_count=64 after the last write.
- Left sample 16'h8000 -> din 32'hFFFF8000; left sample 16'h7FFF -> din 32'h00007FFF.
- CHANNEL=1, left 16'hAAAA, right 16'h5555 -> every din = 32'h00005555, 64 writes.
- Start edge asserted mid-left-slot (bit 5 of 16) -> first write carries the NEXT full left sample. A second start edge during capture is ignored; the write count stays at 64.
- rst asserted after 10 writes -> outputs reset immediately, no further writes. A subsequent start writes from addr 0 and sample_count restarts at 0.

Source files
------------

// File: rtl/i2s_rx_bram_capture.sv
// I2S record-path capture: deserializes one selected channel and writes CLIP_LEN
// sign-extended samples into BRAM, one 32-bit word per sample at consecutive addresses.
module i2s_rx_bram_capture #(
  parameter int unsigned SAMPLE_BITS    = 16,
  parameter int unsigned CLIP_LEN       = 64,
  parameter int unsigned ADDR_INCREMENT = 4,
  parameter int unsigned CHANNEL        = 0
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  output logic        busy,
  output logic        done,
  output logic [15:0] sample_count,
  input  logic        i2s_bclk,
  input  logic        i2s_lrc,
  input  logic        i2s_recdat,
  output logic [31:0] BRAM_addr,
  output logic        BRAM_clk,
  output logic [31:0] BRAM_din,
  output logic        BRAM_en,
  output logic        BRAM_rst,
  output logic [3:0]  BRAM_we
);

  localparam int unsigned    CntW     = $clog2(SAMPLE_BITS + 1);
  localparam logic [CntW-1:0] CntFull = CntW'(SAMPLE_BITS);
  localparam logic [CntW-1:0] CntLast = CntW'(SAMPLE_BITS - 1);
  localparam logic           ChanLrc  = (CHANNEL != 0);

  typedef enum logic [2:0] {StIdle, StArm, StCapture, StWrite, StDone} state_e;

  state_e                 state_q, state_d;
  logic [2:0]             bclk_q, bclk_d;
  logic [1:0]             lrc_q, lrc_d;
  logic [1:0]             recdat_q, recdat_d;
  logic                   lrc_prev_q, lrc_prev_d;
  logic                   slot_lrc_q, slot_lrc_d;
  logic [CntW-1:0]        bit_cnt_q, bit_cnt_d;
  // Only the older SAMPLE_BITS-1 bits are held; the LSB joins them on completion.
  logic [SAMPLE_BITS-2:0] shift_q, shift_d;
  logic                   start_q, start_d;
  logic [15:0]            count_q, count_d;
  logic [31:0]            addr_q, addr_d;
  logic [31:0]            din_q, din_d;
  logic                   en_q, en_d;
  logic [3:0]             we_q, we_d;
  logic                   bram_rst_q, bram_rst_d;

  logic                   bre;
  logic                   lrc_s;
  logic                   boundary;
  logic                   shifting;
  logic                   sample_done;
  logic                   start_edge;
  logic [SAMPLE_BITS-1:0] shift_next;

  // Synchronizers, bit-clock edge detect and slot tracking.
  always_comb begin
    bclk_d   = {bclk_q[1:0], i2s_bclk};
    lrc_d    = {lrc_q[0], i2s_lrc};
    recdat_d = {recdat_q[0], i2s_recdat};

    bre         = bclk_q[1] & ~bclk_q[2];
    lrc_s       = lrc_q[1];
    boundary    = bre && (lrc_s != lrc_prev_q);
    shifting    = bre && (bit_cnt_q != CntFull);
    // The bit on the boundary bre still belongs to the slot being left.
    sample_done = shifting && (bit_cnt_q == CntLast) && (slot_lrc_q == ChanLrc);
    shift_next  = {shift_q, recdat_q[1]};

    lrc_prev_d = bre ? lrc_s : lrc_prev_q;
    slot_lrc_d = boundary ? lrc_s : slot_lrc_q;
    shift_d    = shifting ? shift_next[SAMPLE_BITS-2:0] : shift_q;
    bit_cnt_d  = bit_cnt_q;
    if (shifting) bit_cnt_d = bit_cnt_q + CntW'(1);
    if (boundary) bit_cnt_d = '0;

    start_d    = start;
    start_edge = start & ~start_q;
    bram_rst_d = 1'b0;
  end

  always_comb begin
    state_d = state_q;
    count_d = count_q;
    addr_d  = addr_q;
    din_d   = din_q;
    en_d    = 1'b0;
    we_d    = 4'h0;
    unique case (state_q)
      StIdle, StDone: begin
        if (start_edge) begin
          state_d = StArm;
          count_d = '0;
        end
      end
      StArm: begin
        if (boundary && (lrc_s == ChanLrc)) state_d = StCapture;
      end
      StCapture: begin
        if (sample_done) begin
          state_d = StWrite;
          en_d    = 1'b1;
          we_d    = 4'hF;
          addr_d  = 32'(count_q) * 32'(ADDR_INCREMENT);
          din_d   = 32'($signed(shift_next));
        end
      end
      StWrite: begin
        count_d = count_q + 16'd1;
        state_d = (count_d == 16'(CLIP_LEN)) ? StDone : StCapture;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= StIdle;
      bclk_q     <= '0;
      lrc_q      <= '0;
      recdat_q   <= '0;
      lrc_prev_q <= 1'b0;
      slot_lrc_q <= 1'b0;
      bit_cnt_q  <= CntFull;
      shift_q    <= '0;
      start_q    <= 1'b0;
      count_q    <= '0;
      addr_q     <= '0;
      din_q      <= '0;
      en_q       <= 1'b0;
      we_q       <= 4'h0;
      bram_rst_q <= 1'b1;
    end else begin
      state_q    <= state_d;
      bclk_q     <= bclk_d;
      lrc_q      <= lrc_d;
      recdat_q   <= recdat_d;
      lrc_prev_q <= lrc_prev_d;
      slot_lrc_q <= slot_lrc_d;
      bit_cnt_q  <= bit_cnt_d;
      shift_q    <= shift_d;
      start_q    <= start_d;
      count_q    <= count_d;
      addr_q     <= addr_d;
      din_q      <= din_d;
      en_q       <= en_d;
      we_q       <= we_d;
      bram_rst_q <= bram_rst_d;
    end
  end

  assign busy         = (state_q == StArm) || (state_q == StCapture) || (state_q == StWrite);
  assign done         = (state_q == StDone);
  assign sample_count = count_q;
  assign BRAM_addr    = addr_q;
  assign BRAM_clk     = clk;
  assign BRAM_din     = din_q;
  assign BRAM_en      = en_q;
  assign BRAM_rst     = bram_rst_q;
  assign BRAM_we      = we_q;

endmodule

// File: tb/tb_i2s_rx_bram_capture.sv
// Directed bench: left-channel instance (ramp, sign extension, reset mid-capture)
// and a right-channel instance sharing the same I2S stream.
module tb_i2s_rx_bram_capture;

  logic clk = 1'b0;
  logic rst0 = 1'b1, rst1 = 1'b1;
  logic start0 = 1'b0, start1 = 1'b0;
  logic i2s_bclk = 1'b0, i2s_lrc = 1'b0, i2s_recdat = 1'b0;

  logic        busy0, done0, bclk_o0, en0, brst0;
  logic [15:0] cnt0;
  logic [31:0] addr0, din0;
  logic [3:0]  we0;
  logic        busy1, done1, bclk_o1, en1, brst1;
  logic [15:0] cnt1;
  logic [31:0] addr1, din1;
  logic [3:0]  we1;

  int errors = 0;
  int checks = 0;

  int gen_frame = 0;
  int gen_slot  = 0;
  int gen_bit   = 0;
  int mode      = 0;
  int base      = 0;

  always #5 clk = ~clk;

  i2s_rx_bram_capture #(.CHANNEL(0)) dut0 (
    .clk(clk), .rst(rst0), .start(start0), .busy(busy0), .done(done0), .sample_count(cnt0),
    .i2s_bclk(i2s_bclk), .i2s_lrc(i2s_lrc), .i2s_recdat(i2s_recdat),
    .BRAM_addr(addr0), .BRAM_clk(bclk_o0), .BRAM_din(din0), .BRAM_en(en0),
    .BRAM_rst(brst0), .BRAM_we(we0)
  );

  i2s_rx_bram_capture #(.CHANNEL(1)) dut1 (
    .clk(clk), .rst(rst1), .start(start1), .busy(busy1), .done(done1), .sample_count(cnt1),
    .i2s_bclk(i2s_bclk), .i2s_lrc(i2s_lrc), .i2s_recdat(i2s_recdat),
    .BRAM_addr(addr1), .BRAM_clk(bclk_o1), .BRAM_din(din1), .BRAM_en(en1),
    .BRAM_rst(brst1), .BRAM_we(we1)
  );

  // Mode 0: left = frame - base (ramp), right = its complement.
  // Mode 1: left = 8000, 7FFF, then AAAA; right = 5555.
  function automatic logic [15:0] word_for(input int frame, input int slot);
    logic [15:0] ramp;
    ramp = 16'(frame - base);
    if (mode == 0) return (slot == 0) ? ramp : ~ramp;
    if (slot == 1) return 16'h5555;
    if (frame == base + 1) return 16'h8000;
    if (frame == base + 2) return 16'h7FFF;
    return 16'hAAAA;
  endfunction

  // 16 BCLKs per slot, BCLK = 8 clk periods; LRC flips during the previous slot's LSB.
  initial begin
    logic [15:0] w;
    forever begin
      for (int s = 0; s < 2; s++) begin
        w = word_for(gen_frame, s);
        for (int b = 0; b < 16; b++) begin
          gen_slot   = s;
          gen_bit    = b;
          i2s_bclk   = 1'b0;
          i2s_lrc    = (b == 15) ? (s == 0) : (s == 1);
          i2s_recdat = w[15-b];
          #40 i2s_bclk = 1'b1;
          #40;
        end
      end
      gen_frame++;
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic wait_we(input bit which, output bit got);
    got = 1'b0;
    for (int i = 0; i < 1500 && !got; i++) begin
      @(negedge clk);
      if ((which ? we1 : we0) != 4'h0) got = 1'b1;
    end
  endtask

  task automatic check_write(input bit which, input int k, input logic [31:0] exp_din);
    bit got;
    wait_we(which, got);
    check("write_seen", 32'(got), 32'd1);
    if (got) begin
      check("addr", which ? addr1 : addr0, 32'(k * 4));
      check("din", which ? din1 : din0, exp_din);
      check("we", 32'(which ? we1 : we0), 32'hF);
      check("en", 32'(which ? en1 : en0), 32'd1);
      check("cnt_at_write", 32'(which ? cnt1 : cnt0), 32'(k));
      @(negedge clk);
      check("we_one_clk", 32'(which ? we1 : we0), 32'h0);
      check("cnt_after", 32'(which ? cnt1 : cnt0), 32'(k + 1));
    end
  endtask

  task automatic check_reset0(input string tag);
    check({tag, "_addr"}, addr0, 32'h0);
    check({tag, "_din"}, din0, 32'h0);
    check({tag, "_en"}, 32'(en0), 32'd0);
    check({tag, "_we"}, 32'(we0), 32'h0);
    check({tag, "_brst"}, 32'(brst0), 32'd1);
    check({tag, "_busy"}, 32'(busy0), 32'd0);
    check({tag, "_done"}, 32'(done0), 32'd0);
    check({tag, "_cnt"}, 32'(cnt0), 32'd0);
  endtask

  initial begin
    int seen;

    // Reset state
    #12;
    check_reset0("rst");
    check("rst1_brst", 32'(brst1), 32'd1);
    check("rst1_we", 32'(we1), 32'h0);
    @(negedge clk);
    rst0 = 1'b0;
    rst1 = 1'b0;
    #1 check("brst_hold", 32'(brst0), 32'd1);
    @(negedge clk);
    check("brst_drop0", 32'(brst0), 32'd0);
    check("brst_drop1", 32'(brst1), 32'd0);
    seen = 0;
    repeat (200) begin
      @(negedge clk);
      if (we0 != 4'h0 || we1 != 4'h0) seen++;
    end
    check("idle_no_we", 32'(seen), 32'd0);

    // Capture A: ramp, start mid left slot (bit 5), second start edge ignored
    mode = 0;
    wait (gen_slot == 0 && gen_bit == 5);
    base = gen_frame;
    @(negedge clk);
    start0 = 1'b1;
    @(negedge clk);
    check("busy_armed", 32'(busy0), 32'd1);
    for (int k = 0; k < 64; k++) begin
      check_write(1'b0, k, 32'(k + 1));
      check("busy_cap", 32'(busy0), (k == 63) ? 32'd0 : 32'd1);
      if (k == 10) begin
        start0 = 1'b0;
        @(negedge clk);
        start0 = 1'b1;
      end
    end
    check("done_a", 32'(done0), 32'd1);
    check("cnt_a", 32'(cnt0), 32'd64);
    seen = 0;
    repeat (600) begin
      @(negedge clk);
      if (we0 != 4'h0) seen++;
    end
    check("hold_no_retrig", 32'(seen), 32'd0);
    check("done_held", 32'(done0), 32'd1);

    // Capture B: sign extension, then reset after 10 writes
    start0 = 1'b0;
    mode   = 1;
    @(negedge clk);
    wait (gen_slot == 0 && gen_bit == 5);
    base = gen_frame;
    @(negedge clk);
    start0 = 1'b1;
    @(negedge clk);
    check("done_cleared", 32'(done0), 32'd0);
    for (int k = 0; k < 10; k++) begin
      check_write(1'b0, k, (k == 0) ? 32'hFFFF8000 : (k == 1) ? 32'h00007FFF : 32'hFFFFAAAA);
    end
    rst0   = 1'b1;
    start0 = 1'b0;
    #1 check_reset0("midrst");
    repeat (3) @(negedge clk);
    rst0 = 1'b0;
    @(negedge clk);
    check("brst_drop_b", 32'(brst0), 32'd0);
    seen = 0;
    repeat (300) begin
      @(negedge clk);
      if (we0 != 4'h0) seen++;
    end
    check("post_rst_no_we", 32'(seen), 32'd0);

    // Restart after reset begins at address 0
    mode = 0;
    wait (gen_slot == 0 && gen_bit == 5);
    base = gen_frame;
    @(negedge clk);
    start0 = 1'b1;
    check_write(1'b0, 0, 32'h00000001);
    check_write(1'b0, 1, 32'h00000002);

    // Capture C: right channel instance
    mode = 1;
    wait (gen_slot == 0 && gen_bit == 5);
    base = gen_frame;
    @(negedge clk);
    start1 = 1'b1;
    for (int k = 0; k < 64; k++) check_write(1'b1, k, 32'h00005555);
    check("done_c", 32'(done1), 32'd1);
    check("busy_c", 32'(busy1), 32'd0);
    check("cnt_c", 32'(cnt1), 32'd64);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
